// File: rtl/rd_chan_arbiter.sv
// Shares one AXI read channel between key-init, decrypt-key and encrypt-key requesters, round-robin.
// Latency: request pulse to axi_rvalid is 2 cycles when idle; returned beats reach the owner 1 cycle after acceptance.
// Backpressure: none toward requesters (one-deep buffer each, extra pulses dropped and flagged); axi_rd_rready is held high throughout DATA.
//
// Ports:
//   aclk, areset                      clock and asynchronous active-high reset
//   {key,d,e}_axi_rvalid/raddr        request pulse and address per requester
//   {key,d,e}_axi_rd_rvalid/data/last returned beats, valid/last only toward the burst owner
//   axi_r*                            AXI read address channel (rid = owner index)
//   axi_rd_*                          AXI read data channel
//   req_ovf, rd_err                   sticky error flags
module rd_chan_arbiter #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 512,
    parameter int C_BURST_LEN      = 0
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic                        key_axi_rvalid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] key_axi_raddr,
    input  logic                        d_axi_rvalid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] d_axi_raddr,
    input  logic                        e_axi_rvalid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] e_axi_raddr,

    output logic                        key_axi_rd_rvalid,
    output logic [C_AXI_DATA_WIDTH-1:0] key_axi_rd_data,
    output logic                        key_axi_rd_last,
    output logic                        d_axi_rd_rvalid,
    output logic [C_AXI_DATA_WIDTH-1:0] d_axi_rd_data,
    output logic                        d_axi_rd_last,
    output logic                        e_axi_rd_rvalid,
    output logic [C_AXI_DATA_WIDTH-1:0] e_axi_rd_data,
    output logic                        e_axi_rd_last,

    input  logic                        axi_rready,
    output logic [C_AXI_ID_WIDTH-1:0]   axi_rid,
    output logic [C_AXI_ADDR_WIDTH-1:0] axi_raddr,
    output logic [7:0]                  axi_rlen,
    output logic [2:0]                  axi_rsize,
    output logic [1:0]                  axi_rburst,
    output logic                        axi_rlock,
    output logic [3:0]                  axi_rcache,
    output logic [2:0]                  axi_rprot,
    output logic                        axi_rvalid,

    input  logic [C_AXI_ID_WIDTH-1:0]   axi_rd_bid,
    input  logic [1:0]                  axi_rd_rresp,
    input  logic                        axi_rd_rvalid,
    input  logic [C_AXI_DATA_WIDTH-1:0] axi_rd_data,
    input  logic                        axi_rd_last,
    output logic                        axi_rd_rready,

    output logic [2:0]                  req_ovf,
    output logic                        rd_err
);

    localparam logic [8:0] BEATS_PER_BURST = 9'(C_BURST_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]                  req_vld;
    logic [C_AXI_ADDR_WIDTH-1:0] req_addr [3];

    logic [2:0]                  pend_q;
    logic [C_AXI_ADDR_WIDTH-1:0] pend_addr_q [3];

    logic [1:0]                  rr_last_q;
    logic [1:0]                  gnt_idx;
    logic                        gnt_en;
    logic [2:0]                  gnt_oh;

    logic [1:0]                  owner_q;
    logic [2:0]                  owner_oh;
    logic [C_AXI_ADDR_WIDTH-1:0] gnt_addr_q;

    logic                        beat_hs;
    logic [8:0]                  beat_cnt_q;
    logic [8:0]                  beat_nxt;
    logic                        beat_bad;

    logic [2:0]                  ret_vld_q;
    logic [2:0]                  ret_last_q;
    logic [C_AXI_DATA_WIDTH-1:0] ret_data_q;

    assign req_vld     = {e_axi_rvalid, d_axi_rvalid, key_axi_rvalid};
    assign req_addr[0] = key_axi_raddr;
    assign req_addr[1] = d_axi_raddr;
    assign req_addr[2] = e_axi_raddr;

    // Round-robin: the search starts just after the last address-phase winner.
    always_comb begin
        gnt_idx = 2'd0;
        case (rr_last_q)
            2'd0:    gnt_idx = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
            2'd1:    gnt_idx = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
            default: gnt_idx = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign gnt_oh   = gnt_en ? (3'b001 << gnt_idx) : 3'b000;
    assign owner_oh = 3'b001 << owner_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_en        = 1'b0;
        axi_rvalid    = 1'b0;
        axi_rd_rready = 1'b0;
        beat_hs       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    gnt_en  = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                axi_rd_rready = 1'b1;
                if (axi_rd_rvalid) begin
                    beat_hs = 1'b1;
                    if (axi_rd_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-deep buffer per requester. A pulse landing in the cycle its
    // requester is granted refills the buffer (set beats clear); a pulse
    // against a still-pending buffer is dropped and the old address kept.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pend_q  <= 3'b000;
            req_ovf <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                pend_addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_vld[i]) begin
                    if (pend_q[i] && !gnt_oh[i]) begin
                        req_ovf[i] <= 1'b1;
                    end else begin
                        pend_q[i]      <= 1'b1;
                        pend_addr_q[i] <= req_addr[i];
                    end
                end else if (gnt_oh[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Owner and address are frozen at grant so the address phase stays stable.
    // Requester 0 leads after reset because the pointer starts at 2.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            owner_q    <= 2'd0;
            gnt_addr_q <= '0;
            rr_last_q  <= 2'd2;
        end else begin
            if (gnt_en) begin
                owner_q    <= gnt_idx;
                gnt_addr_q <= pend_addr_q[gnt_idx];
            end
            if (state_q == ST_ADDR && axi_rready) begin
                rr_last_q <= owner_q;
            end
        end
    end

    // Beat count saturates so an over-long burst cannot wrap back to a
    // plausible count before its last beat arrives.
    assign beat_nxt = (beat_cnt_q == 9'h1FF) ? beat_cnt_q : beat_cnt_q + 9'd1;
    assign beat_bad = (axi_rd_rresp != 2'b00)
                   || (axi_rd_bid != C_AXI_ID_WIDTH'(owner_q))
                   || (axi_rd_last ? (beat_nxt != BEATS_PER_BURST)
                                   : (beat_nxt == BEATS_PER_BURST));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_q <= 9'd0;
            rd_err     <= 1'b0;
        end else begin
            if (gnt_en) begin
                beat_cnt_q <= 9'd0;
            end else if (beat_hs) begin
                beat_cnt_q <= beat_nxt;
            end
            if (beat_hs && beat_bad) begin
                rd_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ret_vld_q  <= 3'b000;
            ret_last_q <= 3'b000;
            ret_data_q <= '0;
        end else begin
            ret_vld_q  <= beat_hs ? owner_oh : 3'b000;
            ret_last_q <= (beat_hs && axi_rd_last) ? owner_oh : 3'b000;
            if (beat_hs) begin
                ret_data_q <= axi_rd_data;
            end
        end
    end

    assign key_axi_rd_rvalid = ret_vld_q[0];
    assign d_axi_rd_rvalid   = ret_vld_q[1];
    assign e_axi_rd_rvalid   = ret_vld_q[2];
    assign key_axi_rd_last   = ret_last_q[0];
    assign d_axi_rd_last     = ret_last_q[1];
    assign e_axi_rd_last     = ret_last_q[2];
    assign key_axi_rd_data   = ret_data_q;
    assign d_axi_rd_data     = ret_data_q;
    assign e_axi_rd_data     = ret_data_q;

    assign axi_rid    = C_AXI_ID_WIDTH'(owner_q);
    assign axi_raddr  = gnt_addr_q;
    assign axi_rlen   = 8'(C_BURST_LEN);
    assign axi_rsize  = 3'b110;
    assign axi_rburst = 2'b01;
    assign axi_rlock  = 1'b0;
    assign axi_rcache = 4'b0011;
    assign axi_rprot  = 3'b000;

endmodule

// File: tb/tb_rd_chan_arbiter.sv
// Randomized bench for rd_chan_arbiter with a reference model and a memory-side responder.
// Latency: model predicts outputs cycle by cycle; checks sampled on the falling edge.
// Backpressure: responder drives random address-ready and beat gaps, plus injected faults.
module tb_rd_chan_arbiter;
    localparam int IDW   = 4;
    localparam int AW    = 32;
    localparam int DW    = 512;
    localparam int BL    = 1;
    localparam int NBEAT = BL + 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          key_axi_rvalid, d_axi_rvalid, e_axi_rvalid;
    logic [AW-1:0] key_axi_raddr, d_axi_raddr, e_axi_raddr;
    logic          key_axi_rd_rvalid, d_axi_rd_rvalid, e_axi_rd_rvalid;
    logic [DW-1:0] key_axi_rd_data, d_axi_rd_data, e_axi_rd_data;
    logic          key_axi_rd_last, d_axi_rd_last, e_axi_rd_last;
    logic          axi_rready;
    logic [IDW-1:0] axi_rid;
    logic [AW-1:0] axi_raddr;
    logic [7:0]    axi_rlen;
    logic [2:0]    axi_rsize;
    logic [1:0]    axi_rburst;
    logic          axi_rlock;
    logic [3:0]    axi_rcache;
    logic [2:0]    axi_rprot;
    logic          axi_rvalid;
    logic [IDW-1:0] axi_rd_bid;
    logic [1:0]    axi_rd_rresp;
    logic          axi_rd_rvalid;
    logic [DW-1:0] axi_rd_data;
    logic          axi_rd_last;
    logic          axi_rd_rready;
    logic [2:0]    req_ovf;
    logic          rd_err;

    rd_chan_arbiter #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW), .C_BURST_LEN(BL)
    ) dut (
        .aclk(aclk), .areset(areset),
        .key_axi_rvalid(key_axi_rvalid), .key_axi_raddr(key_axi_raddr),
        .d_axi_rvalid(d_axi_rvalid), .d_axi_raddr(d_axi_raddr),
        .e_axi_rvalid(e_axi_rvalid), .e_axi_raddr(e_axi_raddr),
        .key_axi_rd_rvalid(key_axi_rd_rvalid), .key_axi_rd_data(key_axi_rd_data),
        .key_axi_rd_last(key_axi_rd_last),
        .d_axi_rd_rvalid(d_axi_rd_rvalid), .d_axi_rd_data(d_axi_rd_data),
        .d_axi_rd_last(d_axi_rd_last),
        .e_axi_rd_rvalid(e_axi_rd_rvalid), .e_axi_rd_data(e_axi_rd_data),
        .e_axi_rd_last(e_axi_rd_last),
        .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_raddr(axi_raddr),
        .axi_rlen(axi_rlen), .axi_rsize(axi_rsize), .axi_rburst(axi_rburst),
        .axi_rlock(axi_rlock), .axi_rcache(axi_rcache), .axi_rprot(axi_rprot),
        .axi_rvalid(axi_rvalid),
        .axi_rd_bid(axi_rd_bid), .axi_rd_rresp(axi_rd_rresp),
        .axi_rd_rvalid(axi_rd_rvalid), .axi_rd_data(axi_rd_data),
        .axi_rd_last(axi_rd_last), .axi_rd_rready(axi_rd_rready),
        .req_ovf(req_ovf), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ADDR, M_DATA} mph_t;
    mph_t          m_ph;
    bit   [2:0]    m_pend;
    logic [AW-1:0] m_addr [3];
    int            m_last, m_owner, m_cnt, m_gi;
    logic [AW-1:0] m_gaddr;
    bit            m_err;
    bit   [2:0]    m_ovf;
    bit   [2:0]    x_vld, x_last, o_vld, o_lst, m_pulse;
    logic [DW-1:0] x_data;
    logic [AW-1:0] m_paddr [3];
    int            g_own[$];
    logic [AW-1:0] g_addr[$];

    always @(negedge aclk) begin
        o_vld = {e_axi_rd_rvalid, d_axi_rd_rvalid, key_axi_rd_rvalid};
        o_lst = {e_axi_rd_last, d_axi_rd_last, key_axi_rd_last};
        if (areset) begin
            chk("rst_arvalid", axi_rvalid, 1'b0);
            chk("rst_rready", axi_rd_rready, 1'b0);
            chk("rst_ret_vld", o_vld, 3'b000);
            chk("rst_ovf", req_ovf, 3'b000);
            chk("rst_err", rd_err, 1'b0);
            m_ph = M_IDLE; m_pend = 3'b000; m_last = 2; m_err = 1'b0; m_ovf = 3'b000;
            x_vld = 3'b000; x_last = 3'b000; m_cnt = 0;
        end else begin
            chk("arvalid", axi_rvalid, m_ph == M_ADDR);
            chk("rd_rready", axi_rd_rready, m_ph == M_DATA);
            chk("ret_vld", o_vld, x_vld);
            chk("ret_last", o_lst, x_last);
            if (x_vld != 3'b000) begin
                chk("ret_data_key", key_axi_rd_data, x_data);
                chk("ret_data_d", d_axi_rd_data, x_data);
                chk("ret_data_e", e_axi_rd_data, x_data);
            end
            chk("req_ovf", req_ovf, m_ovf);
            chk("rd_err", rd_err, m_err);
            if (m_ph == M_ADDR) begin
                chk("rid", axi_rid, m_owner);
                chk("raddr", axi_raddr, m_gaddr);
            end
            x_vld = 3'b000; x_last = 3'b000;
            case (m_ph)
                M_IDLE: if (m_pend != 3'b000) begin
                    m_gi = -1;
                    for (int k = 1; k <= 3; k++)
                        if (m_gi < 0 && m_pend[(m_last + k) % 3]) m_gi = (m_last + k) % 3;
                    m_owner = m_gi; m_gaddr = m_addr[m_gi]; m_pend[m_gi] = 1'b0;
                    m_last = m_gi; m_cnt = 0; m_ph = M_ADDR;
                    g_own.push_back(m_gi); g_addr.push_back(m_gaddr);
                end
                M_ADDR: if (axi_rready) m_ph = M_DATA;
                default: if (axi_rd_rvalid) begin
                    m_cnt++;
                    if (axi_rd_rresp != 2'b00 || axi_rd_bid != m_owner) m_err = 1'b1;
                    if (axi_rd_last ? (m_cnt != NBEAT) : (m_cnt == NBEAT)) m_err = 1'b1;
                    x_vld[m_owner] = 1'b1; x_last[m_owner] = axi_rd_last; x_data = axi_rd_data;
                    if (axi_rd_last) m_ph = M_IDLE;
                end
            endcase
            m_pulse = {e_axi_rvalid, d_axi_rvalid, key_axi_rvalid};
            m_paddr[0] = key_axi_raddr; m_paddr[1] = d_axi_raddr; m_paddr[2] = e_axi_raddr;
            for (int i = 0; i < 3; i++) begin
                if (m_pulse[i]) begin
                    if (m_pend[i]) m_ovf[i] = 1'b1;
                    else begin m_pend[i] = 1'b1; m_addr[i] = m_paddr[i]; end
                end
            end
        end
    end

    // ---------------- memory-side responder ----------------
    bit             s_busy, s_err_rand, s_force_resp, s_force_short, s_bad_id;
    int             s_beat, s_len, s_resp_beat, s_rdy_mode, s_stop_at;
    logic [IDW-1:0] s_id;

    initial begin
        axi_rready = 1'b0; axi_rd_rvalid = 1'b0; axi_rd_data = '0; axi_rd_last = 1'b0;
        axi_rd_rresp = 2'b00; axi_rd_bid = '0;
        s_busy = 1'b0; s_beat = 0; s_len = NBEAT; s_resp_beat = -1; s_bad_id = 1'b0; s_id = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                s_busy = 1'b0; s_beat = 0;
            end else if (axi_rvalid && axi_rready) begin
                s_busy = 1'b1; s_beat = 0; s_id = axi_rid; s_len = NBEAT;
                s_resp_beat = -1; s_bad_id = 1'b0;
                if (s_force_short) begin s_len = 1; s_force_short = 1'b0; end
                if (s_force_resp) begin s_resp_beat = 0; s_force_resp = 1'b0; end
                if (s_err_rand) begin
                    if ($urandom_range(0, 7) == 0) s_len = $urandom_range(1, 3);
                    if ($urandom_range(0, 7) == 0) s_resp_beat = $urandom_range(0, s_len - 1);
                    s_bad_id = ($urandom_range(0, 15) == 0);
                end
            end else if (s_busy && axi_rd_rvalid && axi_rd_rready) begin
                s_beat++;
                if (axi_rd_last) s_busy = 1'b0;
            end
            @(posedge aclk); #1;
            case (s_rdy_mode)
                0:       axi_rready = 1'($urandom_range(0, 1));
                1:       axi_rready = 1'b1;
                default: axi_rready = 1'b0;
            endcase
            axi_rd_rvalid = 1'b0; axi_rd_last = 1'b0; axi_rd_rresp = 2'b00;
            if (!areset && s_busy && s_beat < s_stop_at && $urandom_range(0, 3) != 0) begin
                axi_rd_rvalid = 1'b1;
                axi_rd_data   = rnd_data();
                axi_rd_last   = (s_beat == s_len - 1);
                axi_rd_rresp  = (s_beat == s_resp_beat) ? 2'b10 : 2'b00;
                axi_rd_bid    = s_bad_id ? (s_id ^ 4'd1) : s_id;
            end else if (!areset && !s_busy && s_err_rand && $urandom_range(0, 7) == 0) begin
                axi_rd_rvalid = 1'b1;
                axi_rd_data   = rnd_data();
                axi_rd_last   = 1'($urandom_range(0, 1));
                axi_rd_bid    = IDW'($urandom_range(0, 3));
            end
        end
    end

    // ---------------- stimulus ----------------
    int n_wait, alt_bad, d_cnt, d_idx;

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic pulse_req(input bit [2:0] who, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        key_axi_rvalid = who[0]; key_axi_raddr = a0;
        d_axi_rvalid   = who[1]; d_axi_raddr   = a1;
        e_axi_rvalid   = who[2]; e_axi_raddr   = a2;
        tick();
        key_axi_rvalid = 1'b0; d_axi_rvalid = 1'b0; e_axi_rvalid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        n_wait = 0;
        while (n_wait < budget && !(m_ph == M_IDLE && m_pend == 3'b000 && !s_busy)) begin
            tick();
            n_wait++;
        end
        chk("wait_bound", n_wait < budget, 1'b1);
        tick(); tick();
    endtask

    task automatic do_reset();
        tick();
        areset = 1'b1;
        tick(); tick();
        areset = 1'b0;
        g_own.delete(); g_addr.delete();
        tick();
    endtask

    task automatic rand_traffic(input int ncyc, input int pct);
        for (int c = 0; c < ncyc; c++) begin
            key_axi_rvalid = ($urandom_range(0, 99) < pct); key_axi_raddr = $urandom;
            d_axi_rvalid   = ($urandom_range(0, 99) < pct); d_axi_raddr   = $urandom;
            e_axi_rvalid   = ($urandom_range(0, 99) < pct); e_axi_raddr   = $urandom;
            tick();
        end
        key_axi_rvalid = 1'b0; d_axi_rvalid = 1'b0; e_axi_rvalid = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        key_axi_rvalid = 1'b0; d_axi_rvalid = 1'b0; e_axi_rvalid = 1'b0;
        key_axi_raddr = '0; d_axi_raddr = '0; e_axi_raddr = '0;
        s_rdy_mode = 1; s_stop_at = 1000; s_err_rand = 1'b0;
        s_force_resp = 1'b0; s_force_short = 1'b0;
        repeat (3) tick();
        chk("rlen", axi_rlen, 8'd1);
        chk("rsize", axi_rsize, 3'b110);
        chk("rburst", axi_rburst, 2'b01);
        chk("rlock", axi_rlock, 1'b0);
        chk("rcache", axi_rcache, 4'b0011);
        chk("rprot", axi_rprot, 3'b000);
        chk("rst_rid", axi_rid, 0);
        chk("rst_raddr", axi_raddr, 0);
        areset = 1'b0;
        tick();

        // Single key request: address phase two cycles after the pulse.
        pulse_req(3'b001, 32'h0000_1000, '0, '0);
        chk("t1_arvalid_early", axi_rvalid, 1'b0);
        tick();
        chk("t1_arvalid", axi_rvalid, 1'b1);
        chk("t1_raddr", axi_raddr, 32'h0000_1000);
        chk("t1_rid", axi_rid, 0);
        wait_quiet(100);
        chk("t1_grants", g_own.size(), 1);

        // All three at once from reset: 0,1,2, then requester 0 alone.
        do_reset();
        pulse_req(3'b111, 32'h2000, 32'h3000, 32'h4000);
        wait_quiet(200);
        chk("t2_grants", g_own.size(), 3);
        chk("t2_g0", g_own[0], 0);
        chk("t2_g1", g_own[1], 1);
        chk("t2_g2", g_own[2], 2);
        chk("t2_a1", g_addr[1], 32'h3000);
        chk("t2_a2", g_addr[2], 32'h4000);
        pulse_req(3'b001, 32'h5000, '0, '0);
        wait_quiet(100);
        chk("t2_round2", g_own[3], 0);

        // Fairness: d and e requesting every cycle.
        do_reset();
        s_rdy_mode = 0;
        for (int c = 0; c < 200; c++) begin
            d_axi_rvalid = 1'b1; d_axi_raddr = $urandom;
            e_axi_rvalid = 1'b1; e_axi_raddr = $urandom;
            tick();
        end
        d_axi_rvalid = 1'b0; e_axi_rvalid = 1'b0;
        wait_quiet(200);
        alt_bad = 0;
        for (int i = 1; i < g_own.size(); i++)
            if (g_own[i] == g_own[i-1] || g_own[i] == 0) alt_bad++;
        chk("t3_alternate", alt_bad, 0);
        chk("t3_many", g_own.size() > 10, 1'b1);
        chk("t3_ovf", req_ovf, 3'b110);

        // Overflow: second d pulse while the first is still buffered.
        do_reset();
        s_rdy_mode = 2;
        pulse_req(3'b001, 32'h40, '0, '0);
        pulse_req(3'b010, '0, 32'h100, '0);
        tick();
        pulse_req(3'b010, '0, 32'h200, '0);
        chk("t4_ovf", req_ovf, 3'b010);
        s_rdy_mode = 1;
        wait_quiet(200);
        d_cnt = 0; d_idx = 0;
        for (int i = 0; i < g_own.size(); i++) if (g_own[i] == 1) begin d_cnt++; d_idx = i; end
        chk("t4_d_bursts", d_cnt, 1);
        chk("t4_d_addr", g_addr[d_idx], 32'h100);

        // Bad RRESP, then an early last.
        do_reset();
        s_force_resp = 1'b1;
        pulse_req(3'b100, '0, '0, 32'h500);
        wait_quiet(100);
        chk("t5_resp_err", rd_err, 1'b1);
        chk("t5_owner", g_own[0], 2);
        do_reset();
        chk("t5_err_clr", rd_err, 1'b0);
        s_force_short = 1'b1;
        pulse_req(3'b001, 32'h600, '0, '0);
        wait_quiet(100);
        chk("t5_short_err", rd_err, 1'b1);
        chk("t5_idle", axi_rd_rready, 1'b0);
        pulse_req(3'b010, '0, 32'h700, '0);
        wait_quiet(100);
        chk("t5_next", g_own.size(), 2);

        // Random traffic, clean then with injected faults.
        do_reset();
        s_rdy_mode = 0;
        rand_traffic(2000, 10);
        wait_quiet(200);
        do_reset();
        s_err_rand = 1'b1;
        rand_traffic(2000, 12);
        wait_quiet(300);
        s_err_rand = 1'b0;

        // Reset mid-burst with one of two beats received and d pending.
        do_reset();
        s_rdy_mode = 1; s_stop_at = 1;
        pulse_req(3'b001, 32'h800, '0, '0);
        pulse_req(3'b010, '0, 32'h900, '0);
        n_wait = 0;
        while (s_beat < 1 && n_wait < 50) begin tick(); n_wait++; end
        chk("t7_beat_bound", n_wait < 50, 1'b1);
        #2 areset = 1'b1;
        #1;
        chk("t7_arvalid", axi_rvalid, 1'b0);
        chk("t7_rready", axi_rd_rready, 1'b0);
        chk("t7_ret_vld", {e_axi_rd_rvalid, d_axi_rd_rvalid, key_axi_rd_rvalid}, 3'b000);
        chk("t7_rid", axi_rid, 0);
        chk("t7_err", rd_err, 1'b0);
        tick(); tick();
        s_stop_at = 1000;
        areset = 1'b0;
        g_own.delete(); g_addr.delete();
        tick();
        pulse_req(3'b100, '0, '0, 32'hA00);
        wait_quiet(100);
        chk("t7_grants", g_own.size(), 1);
        chk("t7_owner", g_own[0], 2);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end
endmodule
